// File: rtl/rd_addr_ctr_if.sv
// DDR read-request bus between the read address controller and the DDR read engine.
// master = address controller, slave = DDR read engine.
interface rd_addr_ctr_if #(
  parameter int unsigned ADDR_WIDTH   = 30,
  parameter int unsigned RD_NUM_WIDTH = 28
);
  logic                    rd_addr_valid;
  logic [ADDR_WIDTH-1:0]   rd_ddr_addr;
  logic [RD_NUM_WIDTH-1:0] rd_ddr_num;
  logic                    rd_ddr_done;

  modport master (
    output rd_addr_valid,
    output rd_ddr_addr,
    output rd_ddr_num,
    input  rd_ddr_done
  );

  modport slave (
    input  rd_addr_valid,
    input  rd_ddr_addr,
    input  rd_ddr_num,
    output rd_ddr_done
  );
endinterface

// File: rtl/rd_addr_ctr.sv
// Read-side frame address controller: on each display vsync requests a burst read of
// the most recently completed slot of the 8-slot DDR frame ring.
//
// state  | meaning
// IDLE   | waiting for a vsync rise; accepts only once the writer has produced a frame
// ARM    | rd_addr_valid held high for VALID_CYC cycles
// BUSY   | waiting for DDR read done (optional watchdog)
module rd_addr_ctr #(
  parameter logic [31:0]  START_ADDR   = 32'h0080_0000,
  parameter logic [31:0]  BLOCK_SIZE   = 32'h0008_0000,
  parameter logic [31:0]  RD_NUM       = 32'd5400,
  parameter int unsigned  ADDR_WIDTH   = 30,
  parameter int unsigned  RD_NUM_WIDTH = 28,
  parameter int unsigned  VALID_CYC    = 5,
  parameter logic [23:0]  TIMEOUT_CYC  = 24'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rd_vs,
  input  logic [2:0]  i_wr_fram_cnt,
  rd_addr_ctr_if.master ddr,
  output logic [2:0]  o_rd_fram_cnt,
  output logic        o_rd_vs_out,
  output logic        o_rd_repeat,
  output logic        o_rd_vs_miss,
  output logic        o_rd_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  localparam logic [3:0]  VALID_LAST = 4'(VALID_CYC - 1);
  localparam logic [23:0] WD_LAST    = TIMEOUT_CYC - 24'd1;
  localparam bit          WD_EN      = (TIMEOUT_CYC != 24'd0);

  logic [1:0]            r_state;
  logic [2:0]            r_vs_sync;
  logic [2:0]            r_done_sync;
  logic                  r_has_frame;
  logic                  r_prior;
  logic [2:0]            r_last_sel;
  logic [3:0]            r_valid_cnt;
  logic [23:0]           r_wd_cnt;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_fram_cnt;
  logic                  r_vs_out;
  logic                  r_repeat;
  logic                  r_vs_miss;
  logic                  r_err;

  logic                  w_vs_rise;
  logic                  w_done_rise;
  logic [2:0]            w_sel;
  logic [39:0]           w_addr_word;
  logic [39:0]           w_addr_byte;

  assign w_vs_rise   = r_vs_sync[1] & ~r_vs_sync[2];
  assign w_done_rise = r_done_sync[1] & ~r_done_sync[2];

  // Newest complete slot is one behind the writer's counter; 3-bit wrap maps 0 to 7.
  assign w_sel       = i_wr_fram_cnt - 3'd1;
  assign w_addr_word = 40'(START_ADDR) + 40'(w_sel) * 40'(BLOCK_SIZE);
  assign w_addr_byte = {w_addr_word[37:0], 2'b00};

  assign ddr.rd_addr_valid = r_valid;
  assign ddr.rd_ddr_addr   = r_addr;
  assign ddr.rd_ddr_num    = RD_NUM[RD_NUM_WIDTH-1:0];
  assign o_rd_fram_cnt     = r_fram_cnt;
  assign o_rd_vs_out       = r_vs_out;
  assign o_rd_repeat       = r_repeat;
  assign o_rd_vs_miss      = r_vs_miss;
  assign o_rd_err          = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_sync   <= 3'b000;
      r_done_sync <= 3'b000;
      r_has_frame <= 1'b0;
    end else begin
      r_vs_sync   <= {r_vs_sync[1:0], i_rd_vs};
      r_done_sync <= {r_done_sync[1:0], ddr.rd_ddr_done};
      if (i_wr_fram_cnt != 3'd0)
        r_has_frame <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_prior     <= 1'b0;
      r_last_sel  <= 3'd0;
      r_valid_cnt <= 4'd0;
      r_wd_cnt    <= 24'd0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_fram_cnt  <= 3'd0;
      r_vs_out    <= 1'b0;
      r_repeat    <= 1'b0;
      r_vs_miss   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_vs_out  <= 1'b0;
      r_repeat  <= 1'b0;
      r_vs_miss <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_vs_rise) begin
            if (r_has_frame) begin
              r_addr      <= w_addr_byte[ADDR_WIDTH-1:0];
              r_vs_out    <= 1'b1;
              r_repeat    <= r_prior && (w_sel == r_last_sel);
              r_last_sel  <= w_sel;
              r_prior     <= 1'b1;
              r_valid     <= 1'b1;
              r_valid_cnt <= 4'd0;
              r_state     <= S_ARM;
            end else begin
              r_vs_miss <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (w_vs_rise)
            r_vs_miss <= 1'b1;
          if (r_valid_cnt == VALID_LAST) begin
            r_valid  <= 1'b0;
            r_wd_cnt <= 24'd0;
            r_state  <= S_BUSY;
          end else begin
            r_valid_cnt <= r_valid_cnt + 4'd1;
          end
        end
        S_BUSY: begin
          if (w_vs_rise)
            r_vs_miss <= 1'b1;
          // done takes priority over a watchdog expiry in the same cycle
          if (w_done_rise) begin
            r_fram_cnt <= r_last_sel;
            r_state    <= S_IDLE;
          end else if (WD_EN && (r_wd_cnt == WD_LAST)) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else if (WD_EN) begin
            r_wd_cnt <= r_wd_cnt + 24'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rd_addr_ctr.sv
// Directed testbench for rd_addr_ctr, built with a 100-cycle BUSY watchdog.
module tb_rd_addr_ctr;

  logic       clk;
  logic       rst_n;
  logic       rd_vs;
  logic [2:0] wr_fram_cnt;
  logic [2:0] rd_fram_cnt;
  logic       rd_vs_out;
  logic       rd_repeat;
  logic       rd_vs_miss;
  logic       rd_err;

  int n_pass  = 0;
  int n_total = 0;

  rd_addr_ctr_if #(.ADDR_WIDTH(30), .RD_NUM_WIDTH(28)) u_if ();

  rd_addr_ctr #(
    .START_ADDR  (32'h0080_0000),
    .BLOCK_SIZE  (32'h0008_0000),
    .RD_NUM      (32'd5400),
    .ADDR_WIDTH  (30),
    .RD_NUM_WIDTH(28),
    .VALID_CYC   (5),
    .TIMEOUT_CYC (24'd100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rd_vs      (rd_vs),
    .i_wr_fram_cnt(wr_fram_cnt),
    .ddr          (u_if),
    .o_rd_fram_cnt(rd_fram_cnt),
    .o_rd_vs_out  (rd_vs_out),
    .o_rd_repeat  (rd_repeat),
    .o_rd_vs_miss (rd_vs_miss),
    .o_rd_err     (rd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle vsync; returns just after the edge that first samples it high.
  task automatic pulse_vs();
    rd_vs = 1'b1;
    wait_cycles(1);
    rd_vs = 1'b0;
  endtask

  // done sampled at edge M; returns just after edge M+2.
  task automatic finish_read();
    u_if.rd_ddr_done = 1'b1;
    wait_cycles(3);
    u_if.rd_ddr_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd_vs = 1'b0;
    wr_fram_cnt = 3'd0;
    u_if.rd_ddr_done = 1'b0;
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
    n_total++; if (u_if.rd_ddr_addr !== 30'd0) $display("FAIL reset_addr got %h want 0", u_if.rd_ddr_addr); else n_pass++;
    n_total++; if (u_if.rd_ddr_num !== 28'd5400) $display("FAIL ddr_num got %0d want 5400", u_if.rd_ddr_num); else n_pass++;
    n_total++; if (rd_fram_cnt !== 3'd0) $display("FAIL reset_fram got %0d want 0", rd_fram_cnt); else n_pass++;
    n_total++; if (rd_vs_out !== 1'b0) $display("FAIL reset_vs_out got %b want 0", rd_vs_out); else n_pass++;
    n_total++; if (rd_repeat !== 1'b0) $display("FAIL reset_repeat got %b want 0", rd_repeat); else n_pass++;
    n_total++; if (rd_vs_miss !== 1'b0) $display("FAIL reset_miss got %b want 0", rd_vs_miss); else n_pass++;
    n_total++; if (rd_err !== 1'b0) $display("FAIL reset_err got %b want 0", rd_err); else n_pass++;
  endtask

  task automatic test_no_frame();
    int n_miss = 0;
    int n_valid = 0;
    int n_vso = 0;
    wr_fram_cnt = 3'd0;
    pulse_vs();
    for (int i = 0; i < 6; i++) begin
      wait_cycles(1);
      if (rd_vs_miss === 1'b1) n_miss++;
      if (u_if.rd_addr_valid === 1'b1) n_valid++;
      if (rd_vs_out === 1'b1) n_vso++;
    end
    n_total++; if (n_miss != 1) $display("FAIL noframe_miss got %0d pulses want 1", n_miss); else n_pass++;
    n_total++; if (n_valid != 0) $display("FAIL noframe_valid got %0d cycles want 0", n_valid); else n_pass++;
    n_total++; if (n_vso != 0) $display("FAIL noframe_vs_out got %0d pulses want 0", n_vso); else n_pass++;
  endtask

  task automatic test_basic();
    int n_valid = 0;
    int n_vso = 0;
    wr_fram_cnt = 3'd3;
    wait_cycles(2);
    pulse_vs();
    wait_cycles(1);
    n_total++; if (rd_vs_out !== 1'b0) $display("FAIL basic_early_vs_out got %b want 0", rd_vs_out); else n_pass++;
    wait_cycles(1);
    // sel 2: (0x80_0000 + 2*0x8_0000)*4 = 0x240_0000
    n_total++; if (u_if.rd_ddr_addr !== 30'h0240_0000) $display("FAIL basic_addr got %h want 02400000", u_if.rd_ddr_addr); else n_pass++;
    n_total++; if (rd_repeat !== 1'b0) $display("FAIL basic_repeat got %b want 0", rd_repeat); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      if (u_if.rd_addr_valid === 1'b1) n_valid++;
      if (rd_vs_out === 1'b1) n_vso++;
      wait_cycles(1);
    end
    n_total++; if (n_valid != 5) $display("FAIL basic_valid_len got %0d want 5", n_valid); else n_pass++;
    n_total++; if (n_vso != 1) $display("FAIL basic_vs_out_pulses got %0d want 1", n_vso); else n_pass++;
    u_if.rd_ddr_done = 1'b1;
    wait_cycles(2);
    n_total++; if (rd_fram_cnt !== 3'd0) $display("FAIL basic_fram_early got %0d want 0", rd_fram_cnt); else n_pass++;
    wait_cycles(1);
    n_total++; if (rd_fram_cnt !== 3'd2) $display("FAIL basic_fram got %0d want 2", rd_fram_cnt); else n_pass++;
    u_if.rd_ddr_done = 1'b0;
  endtask

  task automatic test_wrap();
    wr_fram_cnt = 3'd0;
    wait_cycles(2);
    pulse_vs();
    wait_cycles(2);
    // sel 7: (0x80_0000 + 7*0x8_0000)*4 = 0x2E0_0000
    n_total++; if (rd_vs_out !== 1'b1) $display("FAIL wrap_vs_out got %b want 1", rd_vs_out); else n_pass++;
    n_total++; if (u_if.rd_ddr_addr !== 30'h02E0_0000) $display("FAIL wrap_addr got %h want 02e00000", u_if.rd_ddr_addr); else n_pass++;
    wait_cycles(5);
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL wrap_busy_valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
    finish_read();
    n_total++; if (rd_fram_cnt !== 3'd7) $display("FAIL wrap_fram got %0d want 7", rd_fram_cnt); else n_pass++;
  endtask

  task automatic test_repeat();
    wr_fram_cnt = 3'd5;
    pulse_vs();
    wait_cycles(2);
    // sel 4: (0x80_0000 + 4*0x8_0000)*4 = 0x280_0000
    n_total++; if (u_if.rd_ddr_addr !== 30'h0280_0000) $display("FAIL rep1_addr got %h want 02800000", u_if.rd_ddr_addr); else n_pass++;
    n_total++; if (rd_repeat !== 1'b0) $display("FAIL rep1_repeat got %b want 0", rd_repeat); else n_pass++;
    wait_cycles(5);
    finish_read();
    pulse_vs();
    wait_cycles(2);
    n_total++; if (rd_vs_out !== 1'b1) $display("FAIL rep2_vs_out got %b want 1", rd_vs_out); else n_pass++;
    n_total++; if (rd_repeat !== 1'b1) $display("FAIL rep2_repeat got %b want 1", rd_repeat); else n_pass++;
    n_total++; if (u_if.rd_ddr_addr !== 30'h0280_0000) $display("FAIL rep2_addr got %h want 02800000", u_if.rd_ddr_addr); else n_pass++;
    wait_cycles(5);
    finish_read();
    n_total++; if (rd_fram_cnt !== 3'd4) $display("FAIL rep_fram got %0d want 4", rd_fram_cnt); else n_pass++;
  endtask

  task automatic test_busy_drop();
    wr_fram_cnt = 3'd6;
    pulse_vs();
    wait_cycles(2);
    // sel 5: (0x80_0000 + 5*0x8_0000)*4 = 0x2A0_0000
    n_total++; if (u_if.rd_ddr_addr !== 30'h02A0_0000) $display("FAIL drop_addr got %h want 02a00000", u_if.rd_ddr_addr); else n_pass++;
    u_if.rd_ddr_done = 1'b1;
    wait_cycles(1);
    u_if.rd_ddr_done = 1'b0;
    wait_cycles(4);
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL drop_reach_busy valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
    n_total++; if (rd_fram_cnt !== 3'd4) $display("FAIL drop_arm_done fram got %0d want 4", rd_fram_cnt); else n_pass++;
    wr_fram_cnt = 3'd7;
    pulse_vs();
    wait_cycles(2);
    n_total++; if (rd_vs_miss !== 1'b1) $display("FAIL drop_miss got %b want 1", rd_vs_miss); else n_pass++;
    n_total++; if (rd_vs_out !== 1'b0) $display("FAIL drop_vs_out got %b want 0", rd_vs_out); else n_pass++;
    n_total++; if (u_if.rd_ddr_addr !== 30'h02A0_0000) $display("FAIL drop_addr_hold got %h want 02a00000", u_if.rd_ddr_addr); else n_pass++;
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL drop_valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
    wait_cycles(3);
    finish_read();
    n_total++; if (rd_fram_cnt !== 3'd5) $display("FAIL drop_fram got %0d want 5", rd_fram_cnt); else n_pass++;
  endtask

  task automatic test_watchdog_reset();
    wr_fram_cnt = 3'd1;
    pulse_vs();
    wait_cycles(2);
    // sel 0: 0x80_0000*4 = 0x200_0000
    n_total++; if (u_if.rd_ddr_addr !== 30'h0200_0000) $display("FAIL wd_addr got %h want 02000000", u_if.rd_ddr_addr); else n_pass++;
    wait_cycles(5);
    wait_cycles(99);
    n_total++; if (rd_err !== 1'b0) $display("FAIL wd_early_err got %b want 0", rd_err); else n_pass++;
    wait_cycles(1);
    n_total++; if (rd_err !== 1'b1) $display("FAIL wd_err got %b want 1", rd_err); else n_pass++;
    n_total++; if (rd_fram_cnt !== 3'd5) $display("FAIL wd_fram got %0d want 5", rd_fram_cnt); else n_pass++;
    pulse_vs();
    wait_cycles(2);
    n_total++; if (rd_vs_out !== 1'b1) $display("FAIL wd_idle_accept got %b want 1", rd_vs_out); else n_pass++;
    n_total++; if (rd_repeat !== 1'b1) $display("FAIL wd_repeat got %b want 1", rd_repeat); else n_pass++;
    n_total++; if (rd_err !== 1'b1) $display("FAIL wd_err_sticky got %b want 1", rd_err); else n_pass++;
    wait_cycles(1);
    n_total++; if (u_if.rd_addr_valid !== 1'b1) $display("FAIL arm_valid got %b want 1", u_if.rd_addr_valid); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL async_rst_valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
    n_total++; if (rd_err !== 1'b0) $display("FAIL async_rst_err got %b want 0", rd_err); else n_pass++;
    n_total++; if (u_if.rd_ddr_addr !== 30'd0) $display("FAIL async_rst_addr got %h want 0", u_if.rd_ddr_addr); else n_pass++;
    n_total++; if (rd_fram_cnt !== 3'd0) $display("FAIL async_rst_fram got %0d want 0", rd_fram_cnt); else n_pass++;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(3);
    n_total++; if (u_if.rd_addr_valid !== 1'b0) $display("FAIL post_rst_valid got %b want 0", u_if.rd_addr_valid); else n_pass++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    rd_vs = 1'b0;
    wr_fram_cnt = 3'd0;
    u_if.rd_ddr_done = 1'b0;
    #1;
    test_reset();
    test_no_frame();
    test_basic();
    test_wrap();
    test_repeat();
    test_busy_drop();
    test_watchdog_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
